// File: rtl/game_ctrl.sv
// Two-player 15x15 connect-WIN_LEN controller: shape selection, cursor moves, stone
// placement and a sequential one-cell-per-cycle win check over four line directions.
module game_ctrl #(
  parameter int WIN_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_center,
  output logic [14:0][14:0][1:0]  grid,
  output logic [3:0]              cursor_x,
  output logic [3:0]              cursor_y,
  output logic                    player_turn,
  output logic [1:0]              state,
  output logic [1:0]              p1_shape,
  output logic [1:0]              p2_shape,
  output logic [1:0]              preview_shape,
  output logic [1:0]              winner
);

  localparam logic [1:0] S_SELECT_P1 = 2'd0;
  localparam logic [1:0] S_SELECT_P2 = 2'd1;
  localparam logic [1:0] S_PLAY      = 2'd2;
  localparam logic [1:0] S_WIN       = 2'd3;
  localparam logic [4:0] WIN_RUN     = 5'(WIN_LEN);
  localparam logic [3:0] K_MAX       = 4'(WIN_LEN - 1);

  logic [1:0]              state_q, state_d;
  logic [14:0][14:0][1:0]  grid_q, grid_d;
  logic [3:0]              cx_q, cx_d, cy_q, cy_d;
  logic                    turn_q, turn_d;
  logic [1:0]              p1_q, p1_d, p2_q, p2_d, prev_q, prev_d, winner_q, winner_d;
  logic [7:0]              moves_q, moves_d;
  logic                    chk_q, chk_d;
  logic [2:0]              si_q, si_d;
  logic [3:0]              k_q, k_d;
  logic [4:0]              run_q, run_d;

  logic act_c, act_u, act_d, act_l, act_r;
  logic [13:0] probe_s, probe_nx_s;
  logic        probe_ok_s;
  logic [3:0]  px_s, py_s, side_first_s, side_nx_s;
  logic [1:0]  cell_s, mark_s;
  logic        match_s, win_s, cont_s, done_s, place_s;
  logic [4:0]  run_inc_s;

  // Probe cell for side si (bit0 = negative side) at distance k+1, packed as {x, y} signed.
  function automatic logic [13:0] probe_xy(input logic [2:0] si, input logic [3:0] k,
                                           input logic [3:0] cx, input logic [3:0] cy);
    logic signed [6:0] dx, dy, off, x, y;
    case (si[2:1])
      2'd0:    begin dx = 7'sd1; dy = 7'sd0;  end
      2'd1:    begin dx = 7'sd0; dy = 7'sd1;  end
      2'd2:    begin dx = 7'sd1; dy = 7'sd1;  end
      2'd3:    begin dx = 7'sd1; dy = -7'sd1; end
      default: begin dx = 7'sd0; dy = 7'sd0;  end
    endcase
    if (si[0]) begin
      dx = -dx;
      dy = -dy;
    end else begin
      dx = dx;
      dy = dy;
    end
    off = $signed({3'b000, k}) + 7'sd1;
    x   = $signed({3'b000, cx}) + dx * off;
    y   = $signed({3'b000, cy}) + dy * off;
    return {x, y};
  endfunction

  function automatic logic in_board(input logic [13:0] xy);
    return !xy[13] && (xy[12:7] <= 6'd14) && !xy[6] && (xy[5:0] <= 6'd14);
  endfunction

  // First side at or after start whose nearest cell is on the board; 8 means none left.
  function automatic logic [3:0] first_side(input logic [3:0] start,
                                            input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if ((4'(i) >= start) && in_board(probe_xy(3'(i), 4'd0, cx, cy))) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign act_c = btn_center;
  assign act_u = !btn_center && btn_up;
  assign act_d = !btn_center && !btn_up && btn_down;
  assign act_l = !btn_center && !btn_up && !btn_down && btn_left;
  assign act_r = !btn_center && !btn_up && !btn_down && !btn_left && btn_right;

  // Win-check datapath: evaluate the current probe and where the scan goes next.
  always_comb begin
    mark_s       = turn_q ? 2'd2 : 2'd1;
    probe_s      = probe_xy(si_q, k_q, cx_q, cy_q);
    probe_ok_s   = in_board(probe_s);
    px_s         = probe_ok_s ? probe_s[10:7] : 4'd0;
    py_s         = probe_ok_s ? probe_s[3:0]  : 4'd0;
    cell_s       = grid_q[py_s][px_s];
    match_s      = chk_q && probe_ok_s && (cell_s == mark_s);
    run_inc_s    = run_q + {4'd0, match_s};
    win_s        = match_s && ((run_inc_s + 5'd1) >= WIN_RUN);
    probe_nx_s   = probe_xy(si_q, k_q + 4'd1, cx_q, cy_q);
    cont_s       = match_s && in_board(probe_nx_s) && ((k_q + 4'd1) < K_MAX);
    side_nx_s    = first_side({1'b0, si_q} + 4'd1, cx_q, cy_q);
    side_first_s = first_side(4'd0, cx_q, cy_q);
    done_s       = chk_q && !win_s && !cont_s && side_nx_s[3];
    place_s      = (state_q == S_PLAY) && !chk_q && act_c && (grid_q[cy_q][cx_q] == 2'd0);
  end

  // State register plus all datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_SELECT_P1;
      grid_q   <= '0;
      cx_q     <= 4'd7;
      cy_q     <= 4'd7;
      turn_q   <= 1'b0;
      p1_q     <= 2'd0;
      p2_q     <= 2'd0;
      prev_q   <= 2'd0;
      winner_q <= 2'd0;
      moves_q  <= 8'd0;
      chk_q    <= 1'b0;
      si_q     <= 3'd0;
      k_q      <= 4'd0;
      run_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      turn_q   <= turn_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      prev_q   <= prev_d;
      winner_q <= winner_d;
      moves_q  <= moves_d;
      chk_q    <= chk_d;
      si_q     <= si_d;
      k_q      <= k_d;
      run_q    <= run_d;
    end
  end

  // Next-state logic of the top-level FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SELECT_P1: if (act_c) state_d = S_SELECT_P2; else state_d = state_q;
      S_SELECT_P2: if (act_c && (prev_q != p1_q)) state_d = S_PLAY; else state_d = state_q;
      S_PLAY:      if (win_s || (done_s && (moves_q == 8'd225))) state_d = S_WIN;
                   else state_d = state_q;
      S_WIN:       if (act_c) state_d = S_PLAY; else state_d = state_q;
      default:     state_d = S_SELECT_P1;
    endcase
  end

  // Datapath next values: shapes, cursor, board, turn, winner and the check-phase scan.
  always_comb begin
    grid_d   = grid_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    turn_d   = turn_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    prev_d   = prev_q;
    winner_d = winner_q;
    moves_d  = moves_q;
    chk_d    = chk_q;
    si_d     = si_q;
    k_d      = k_q;
    run_d    = run_q;
    case (state_q)
      S_SELECT_P1: begin
        if (act_c) begin
          p1_d   = prev_q;
          prev_d = prev_q + 2'd1;
        end else if (act_l) prev_d = prev_q - 2'd1;
        else if (act_r)     prev_d = prev_q + 2'd1;
        else                prev_d = prev_q;
      end
      S_SELECT_P2: begin
        if (act_c) begin
          if (prev_q != p1_q) p2_d = prev_q; else p2_d = p2_q;
        end else if (act_l) prev_d = prev_q - 2'd1;
        else if (act_r)     prev_d = prev_q + 2'd1;
        else                prev_d = prev_q;
      end
      S_PLAY: begin
        if (chk_q) begin
          if (win_s) begin
            winner_d = mark_s;
            chk_d    = 1'b0;
          end else if (cont_s) begin
            k_d   = k_q + 4'd1;
            run_d = run_inc_s;
          end else if (!side_nx_s[3]) begin
            si_d  = side_nx_s[2:0];
            k_d   = 4'd0;
            run_d = (side_nx_s[2:1] == si_q[2:1]) ? run_inc_s : 5'd0;
          end else begin
            chk_d = 1'b0;
            if (moves_q == 8'd225) winner_d = 2'd0; else turn_d = ~turn_q;
          end
        end else if (act_c) begin
          if (place_s) begin
            grid_d[cy_q][cx_q] = mark_s;
            moves_d = moves_q + 8'd1;
            chk_d   = 1'b1;
            si_d    = side_first_s[2:0];
            k_d     = 4'd0;
            run_d   = 5'd0;
          end else chk_d = 1'b0;
        end else if (act_u) cy_d = (cy_q == 4'd0)  ? 4'd14 : cy_q - 4'd1;
        else if (act_d)     cy_d = (cy_q == 4'd14) ? 4'd0  : cy_q + 4'd1;
        else if (act_l)     cx_d = (cx_q == 4'd0)  ? 4'd14 : cx_q - 4'd1;
        else if (act_r)     cx_d = (cx_q == 4'd14) ? 4'd0  : cx_q + 4'd1;
        else                cx_d = cx_q;
      end
      S_WIN: begin
        if (act_c) begin
          grid_d   = '0;
          moves_d  = 8'd0;
          cx_d     = 4'd7;
          cy_d     = 4'd7;
          turn_d   = 1'b0;
          winner_d = 2'd0;
          chk_d    = 1'b0;
        end else chk_d = 1'b0;
      end
      default: chk_d = 1'b0;
    endcase
  end

  assign grid          = grid_q;
  assign cursor_x      = cx_q;
  assign cursor_y      = cy_q;
  assign player_turn   = turn_q;
  assign state         = state_q;
  assign p1_shape      = p1_q;
  assign p2_shape      = p2_q;
  assign preview_shape = prev_q;
  assign winner        = winner_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports: btn_up, btn_down, btn_left, btn_right, btn_center  in  1 each  single-cycle, already-debounced press pulses.
REQ-004 SHALL have port: grid  out  2 x [14:0][14:0]  board, indexed grid[y][x]; 0 empty, 1 P1, 2 P2; 3 never driven.
REQ-005 SHALL have ports: cursor_x, cursor_y  out  4 each  cursor cell, range 0..14.
REQ-006 SHALL have port: player_turn  out  1  0 = P1 to move, 1 = P2.
REQ-007 SHALL have port: state  out  state_t  one of S_SELECT_P1, S_SELECT_P2, S_PLAY, S_WIN.
REQ-008 SHALL have ports: p1_shape, p2_shape, preview_shape  out  2 each  shape codes 0 circle, 1 square, 2 diamond, 3 plus.
REQ-009 SHALL have port: winner  out  2  0 draw/none, 1 P1, 2 P2; valid in S_WIN.
REQ-010 SHALL have parameter: WIN_LEN, default 5, run length that wins.

Function
REQ-011 Input priority per cycle: center > up > down > left > right; at most one action per cycle; others dropped, never queued.
REQ-012 S_SELECT_P1: left/right decrement/increment preview_shape mod 4 (0 -> 3 on left, 3 -> 0 on right); up/down ignored.
REQ-013 S_SELECT_P1 + center: p1_shape <= preview_shape, preview_shape <= (preview_shape+1) mod 4, next cycle S_SELECT_P2.
REQ-014 S_SELECT_P2: left/right as REQ-012; center with preview_shape == p1_shape ignored; otherwise p2_shape <= preview_shape, next cycle S_PLAY.
REQ-015 Cursor frozen in select states.
REQ-016 S_PLAY idle: arrows move cursor by 1 with wrap-around (x: 14 -> 0 right, 0 -> 14 left; y: 14 -> 0 down, 0 -> 14 up).
REQ-017 S_PLAY idle + center on empty cell: grid[cursor_y][cursor_x] <= player_turn+1 at that edge, move counter +1, enter check phase; center on occupied cell ignored.
REQ-018 Check phase (internal, state output stays S_PLAY): all buttons ignored; directions checked in order horizontal, vertical, diagonal (+x,+y), anti-diagonal (+x,-y).
REQ-019 Per direction: probe positive side, then negative side, one cell per cycle; side ends on board edge (no probe cycle), mismatch (that cycle), or WIN_LEN-1 matches; run = 1 + matches of both sides.
REQ-020 run >= WIN_LEN: cycle after the deciding probe, state <= S_WIN, winner <= player_turn+1, player_turn unchanged; remaining directions skipped.
REQ-021 No win after all directions: if move counter == 225, S_WIN with winner 0; else player_turn toggles, return to idle.
REQ-022 Check-phase latency from placement edge to idle/S_WIN SHALL be <= 4*2*(WIN_LEN-1)+2 cycles (34 at default); no combinational path from grid to state.
REQ-023 Runs longer than WIN_LEN SHALL also win.
REQ-024 S_WIN: only center acts; it clears all grid cells, move counter 0, cursor (7,7), player_turn 0, winner 0, state S_PLAY in one cycle; shapes retained.
REQ-025 All outputs registered.

Reset
REQ-026 rst_n low at a clock edge: grid all 0, cursor (7,7), player_turn 0, state S_SELECT_P1, p1_shape/p2_shape/preview_shape 0, winner 0, move counter 0, check phase aborted.
REQ-027 Reset SHALL dominate any simultaneous button pulse; reset mid-check leaves no partial placement or turn change.

Verification
REQ-028 Select: right x3, center, right, center -> p1_shape 3, preview after first center 0, p2_shape 1, state S_PLAY; center while preview==p1_shape -> no change.
REQ-029 Wrap: cursor (7,7), 8x right -> cursor_x 0; from (0,0) up -> cursor_y 14.
REQ-030 Horizontal win: P1 at (3..7,5) interleaved with P2 elsewhere, P1 fills middle (5,5) last -> S_WIN within 34 cycles, winner 1, player_turn 0.
REQ-031 Edge/anti-diagonal: P2 run (14,0),(13,1),(12,2),(11,3),(10,4) -> winner 2; 4-long run at edge -> no win, player_turn toggles.
REQ-032 Occupied cell + center -> grid, player_turn, move counter unchanged; buttons during check -> ignored.
REQ-033 Reset asserted mid-check and 225-move no-win fill -> REQ-026 values; full board -> S_WIN winner 0; then center -> empty grid, S_PLAY.
